data_mem_master: RTL and testbench

Initiator side of the 64 x 8 data RAM port. It accepts single-beat or burst load/store requests from the core, or from a loader/dumper, on a valid/ready request channel. It sequences the RAM's address, write-data and level-sensitive write-enable pins with guaranteed setup and hold. Load data streams out on a valid/ready channel with backpressure; store data streams in the same way.

---
 rtl/data_mem_pkg.sv | 23 ++
 rtl/data_mem_addr_gen.sv | 34 +++
 rtl/data_mem_master.sv | 127 ++++++++++++
 tb/tb_data_mem_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants, state encoding and operation codes for the data RAM initiator.
package data_mem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

endpackage

// File: rtl/data_mem_addr_gen.sv
// Burst address register with modulo increment, plus the remaining-beat down-counter.
module data_mem_addr_gen
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [LEN_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            o_addr  <= i_addr;
            r_count <= i_len;
        end else if (i_step) begin
            // Address wraps naturally at 2^ADDR_W.
            o_addr  <= o_addr + ADDR_W'(1);
            r_count <= r_count - LEN_W'(1);
        end
    end

    assign o_last = (r_count == '0);

endmodule

// File: rtl/data_mem_master.sv
// Initiator for the 64 x 8 data RAM: sequences load/store bursts with write-enable setup and hold.
module data_mem_master
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    input  logic [DATA_W-1:0] read_data
);

    state_t r_state;
    op_t    r_op;
    logic   w_load;
    logic   w_last;
    logic   w_beat_done;
    logic   w_step;

    assign w_load      = (r_state == ST_IDLE) && req_valid;
    assign w_beat_done = (r_op == OP_LOAD) ? (r_state == ST_RD_DATA && rd_valid && rd_ready)
                                           : (r_state == ST_WR_HOLD);
    assign w_step      = w_beat_done && !w_last;

    data_mem_addr_gen u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_addr (req_addr),
        .i_len  (req_len),
        .i_step (w_step),
        .o_addr (data_address),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LOAD;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            wr_ready     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op      <= op_t'(req_write);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_write) begin
                            r_state  <= ST_WR_DATA;
                            wr_ready <= 1'b1;
                        end else begin
                            r_state  <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    // Address has been stable a full cycle; the RAM read is settled.
                    r_state  <= ST_RD_DATA;
                    rd_data  <= read_data;
                    rd_valid <= 1'b1;
                    rd_last  <= w_last;
                end
                ST_RD_DATA: begin
                    if (w_beat_done) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (w_last) begin
                            r_state   <= ST_IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (wr_valid) begin
                        write_data <= wr_data;
                        wr_ready   <= 1'b0;
                        r_state    <= ST_WR_SETUP;
                    end
                end
                ST_WR_SETUP: begin
                    r_state      <= ST_WR_STROBE;
                    write_enable <= 1'b1;
                end
                ST_WR_STROBE: begin
                    r_state      <= ST_WR_HOLD;
                    write_enable <= 1'b0;
                end
                ST_WR_HOLD: begin
                    // Address may only move here, after the strobe has been low a full cycle.
                    if (w_last) begin
                        r_state   <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_state  <= ST_WR_DATA;
                        wr_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Self-checking bench for data_mem_master with a behavioural 64 x 8 RAM and strobe monitor.
module tb_data_mem_master;
    import data_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, rd_last, rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic [DATA_W-1:0] read_data;

    always #5 clk = ~clk;

    data_mem_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .data_address (data_address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data)
    );

    // RAM model: level-sensitive write sampled at the clock edge, combinational read.
    logic [7:0] mem [64];
    logic       fill;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'hC3;
        end else if (write_enable) begin
            mem[data_address] <= write_data;
        end
    end
    assign read_data = mem[data_address];

    // Strobe monitor: counts pulses and flags address/data motion around the strobe.
    int         pulses = 0;
    int         viol   = 0;
    logic       we_prev = 1'b0, rst_prev = 1'b1;
    logic [5:0] a_prev = '0;
    logic [7:0] d_prev = '0;
    always @(negedge clk) begin
        if (!rst_prev) begin
            if (write_enable && !we_prev) pulses++;
            if ((write_enable || we_prev) && (data_address !== a_prev || write_data !== d_prev)) viol++;
            if (write_enable && we_prev) viol++;
        end
        we_prev  = write_enable;
        a_prev   = data_address;
        d_prev   = write_data;
        rst_prev = reset;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] gold [64];
    logic [7:0] wbuf [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(req_ready), 32'd1);
    endtask

    task automatic issue_req(input logic wr, input logic [5:0] addr, input logic [5:0] len);
        wait_idle("req_idle");
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("wr_ready_wait", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic store_burst(input logic [5:0] addr, input logic [5:0] len);
        logic [5:0] a;
        issue_req(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 6'(i);
            send_beat(wbuf[i]);
            gold[a] = wbuf[i];
        end
        wait_idle("store_done");
    endtask

    task automatic load_burst(input logic [5:0] addr, input logic [5:0] len,
                              input int stall_beat, input int stall_n);
        int         p0 = pulses;
        int         t;
        logic [5:0] a;
        rd_ready = 1'b1;
        issue_req(1'b0, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 6'(i);
            t = 0;
            while (!rd_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("rd_valid_wait", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(gold[a]));
            check("rd_last", 32'(rd_last), 32'(i == int'(len)));
            if (i == stall_beat) begin
                rd_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_valid", 32'(rd_valid), 32'd1);
                    check("stall_data", 32'(rd_data), 32'(gold[a]));
                    check("stall_last", 32'(rd_last), 32'(i == int'(len)));
                    check("stall_addr", 32'(data_address), 32'(a));
                end
                rd_ready = 1'b1;
            end
            @(negedge clk);
        end
        wait_idle("load_done");
        check("no_write_in_load", 32'(pulses - p0), 32'd0);
    endtask

    // Single-beat load with exact latency: valid appears after the second edge from accept.
    task automatic load_single(input logic [5:0] addr, input logic [7:0] exp);
        wait_idle("ls_idle");
        rd_ready  = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = 6'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("ls_early_valid", 32'(rd_valid), 32'd0);
        check("ls_addr", 32'(data_address), 32'(addr));
        @(negedge clk);
        check("ls_valid", 32'(rd_valid), 32'd1);
        check("ls_data", 32'(rd_data), 32'(exp));
        check("ls_last", 32'(rd_last), 32'd1);
        rd_ready = 1'b1;
        @(negedge clk);
        check("ls_valid_drop", 32'(rd_valid), 32'd0);
        check("ls_req_ready", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int p;
        vecs[0] = '{1'b1, 6'h05, 8'hA5};
        vecs[1] = '{1'b0, 6'h05, 8'hA5};
        vecs[2] = '{1'b1, 6'h3F, 8'h5A};
        vecs[3] = '{1'b0, 6'h3F, 8'h5A};
        vecs[4] = '{1'b1, 6'h00, 8'hFF};
        vecs[5] = '{1'b0, 6'h00, 8'hFF};
        vecs[6] = '{1'b0, 6'h05, 8'hA5};
        for (int i = 0; i < 64; i++) gold[i] = 8'(i) ^ 8'hC3;

        reset = 1'b1; fill = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_addr", 32'(data_address), 32'd0);
        check("rst_wdata", 32'(write_data), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        reset = 1'b0; fill = 1'b0;
        @(negedge clk);

        // Reset asserted while the strobe is high.
        issue_req(1'b1, 6'h10, 6'd0);
        send_beat(8'h77);
        p = 0;
        while (!write_enable && p < 20) begin
            @(negedge clk);
            p++;
        end
        check("t1_strobe_seen", 32'(write_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t1_we", 32'(write_enable), 32'd0);
        check("t1_req_ready", 32'(req_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        p = pulses;
        repeat (5) @(negedge clk);
        check("t1_no_more_writes", 32'(pulses - p), 32'd0);
        check("t1_line", 32'(mem[6'h10] == 8'hD3 || mem[6'h10] == 8'h77), 32'd1);
        gold[6'h10] = mem[6'h10];

        // Table of single-beat stores and loads.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) begin
                p = pulses;
                wbuf[0] = vecs[i].data;
                store_burst(vecs[i].addr, 6'd0);
                check("vec_pulse", 32'(pulses - p), 32'd1);
            end else begin
                load_single(vecs[i].addr, vecs[i].data);
            end
        end

        // Wrapping store burst, then load back over the same span.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        p = pulses;
        store_burst(6'h3E, 6'd3);
        check("t3_pulses", 32'(pulses - p), 32'd4);
        check("t3_mem3e", 32'(mem[6'h3E]), 32'h11);
        check("t3_mem3f", 32'(mem[6'h3F]), 32'h22);
        check("t3_mem00", 32'(mem[6'h00]), 32'h33);
        check("t3_mem01", 32'(mem[6'h01]), 32'h44);
        load_burst(6'h3E, 6'd3, -1, 0);

        // Backpressure on the second beat.
        load_burst(6'h3E, 6'd2, 1, 5);

        // Delayed store data while another request is offered.
        issue_req(1'b1, 6'h2A, 6'd0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h15; req_len = 6'd0;
        p = pulses;
        for (int k = 0; k < 3; k++) begin
            check("t5_wr_ready", 32'(wr_ready), 32'd1);
            check("t5_we", 32'(write_enable), 32'd0);
            check("t5_req_ready", 32'(req_ready), 32'd0);
            check("t5_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        send_beat(8'h6C);
        wait_idle("t5_done");
        check("t5_pulses", 32'(pulses - p), 32'd1);
        check("t5_addr_kept", 32'(data_address), 32'h2A);
        gold[6'h2A] = 8'h6C;
        load_single(6'h2A, 8'h6C);

        // Full sweep: every line written with its own address.
        for (int i = 0; i < 64; i++) wbuf[i] = 8'((32 + i) % 64);
        p = pulses;
        store_burst(6'h20, 6'd63);
        check("t6_pulses", 32'(pulses - p), 32'd64);
        check("t6_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 64; i++) check("t6_mem", 32'(mem[i]), 32'(i));
        load_burst(6'h20, 6'd63, -1, 0);
        check("t6_rd_req_ready", 32'(req_ready), 32'd1);

        check("strobe_stability", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
